// File: rtl/fetch_sequencer.sv
// Fetch and control-flow sequencer for the MachineV core: steps the program
// counter and A-bus strobes through fetch, branch decode and executor handoff.
module fetch_sequencer #(
  parameter int OPW  = 3,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            run,
  input  logic            halt_req,
  input  logic [OPW-1:0]  opcode,
  input  logic            zflag,
  input  logic            mem_ack,
  input  logic            exec_done,
  output logic            Lout,
  output logic            Lin,
  output logic            inc,
  output logic            Ain,
  output logic            mem_rd,
  output logic            Iin,
  output logic            IAout,
  output logic            exec_start,
  output logic            busy,
  output logic            halted,
  output logic [CNTW-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_M,
    S_FETCH_I,
    S_DECODE,
    S_JUMP,
    S_EXEC,
    S_EXEC_W,
    S_END,
    S_HALTED
  } state_t;

  localparam logic [OPW-1:0] OP_NOP = OPW'(0);
  localparam logic [OPW-1:0] OP_JMP = OPW'(1);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(2);
  localparam logic [OPW-1:0] OP_HLT = OPW'(3);

  state_t          r_state;
  state_t          w_next;
  logic [CNTW-1:0] r_count;
  logic            w_retire;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_count <= r_count + CNTW'(1);
    end
  end

  // HLT retires on its way into HALTED since it never passes through END.
  assign w_retire = (r_state == S_END) ||
                    ((r_state == S_DECODE) && (opcode == OP_HLT));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (run) w_next = S_FETCH_A;
      S_FETCH_A: w_next = S_FETCH_M;
      S_FETCH_M: if (mem_ack) w_next = S_FETCH_I;
      S_FETCH_I: w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_NOP:  w_next = S_END;
          OP_JMP:  w_next = S_JUMP;
          OP_JZ:   w_next = zflag ? S_JUMP : S_END;
          OP_HLT:  w_next = S_HALTED;
          default: w_next = S_EXEC;
        endcase
      end
      S_JUMP:    w_next = S_END;
      S_EXEC:    w_next = S_EXEC_W;
      S_EXEC_W:  if (exec_done) w_next = S_END;
      S_END:     w_next = halt_req ? S_HALTED : S_FETCH_A;
      S_HALTED:  if (run) w_next = S_FETCH_A;
      default:   w_next = S_IDLE;
    endcase
  end

  // Moore decode: strobes depend on the state register alone.
  always_comb begin
    Lout       = 1'b0;
    Lin        = 1'b0;
    inc        = 1'b0;
    Ain        = 1'b0;
    mem_rd     = 1'b0;
    Iin        = 1'b0;
    IAout      = 1'b0;
    exec_start = 1'b0;
    busy       = (r_state != S_IDLE) && (r_state != S_HALTED);
    halted     = (r_state == S_HALTED);
    case (r_state)
      S_FETCH_A: begin
        Lout = 1'b1;
        Ain  = 1'b1;
      end
      S_FETCH_M: mem_rd = 1'b1;
      S_FETCH_I: begin
        Iin = 1'b1;
        inc = 1'b1;
      end
      S_JUMP: begin
        IAout = 1'b1;
        Lin   = 1'b1;
      end
      S_EXEC:  exec_start = 1'b1;
      default: ;
    endcase
  end

  assign instr_count = r_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle strobe patterns, retire count
// and bus-driver exclusivity, with a 4-bit counter so wrap is reachable.
module tb_fetch_sequencer;

  localparam int OPW  = 3;
  localparam int CNTW = 4;

  // strobe vector order: Lout Lin inc Ain mem_rd Iin IAout exec_start busy halted
  localparam logic [9:0] V_ID = 10'b0000000000;
  localparam logic [9:0] V_FA = 10'b1001000010;
  localparam logic [9:0] V_FM = 10'b0000100010;
  localparam logic [9:0] V_FI = 10'b0010010010;
  localparam logic [9:0] V_BZ = 10'b0000000010;
  localparam logic [9:0] V_JP = 10'b0100001010;
  localparam logic [9:0] V_EX = 10'b0000000110;
  localparam logic [9:0] V_HL = 10'b0000000001;

  logic            CLK;
  logic            nRST;
  logic            run;
  logic            halt_req;
  logic [OPW-1:0]  opcode;
  logic            zflag;
  logic            mem_ack;
  logic            exec_done;
  logic            Lout, Lin, inc, Ain, mem_rd, Iin, IAout, exec_start, busy, halted;
  logic [CNTW-1:0] instr_count;
  logic [9:0]      obs;
  logic [CNTW-1:0] exp_cnt;
  int              n_vec;
  int              n_err;

  fetch_sequencer #(.OPW(OPW), .CNTW(CNTW)) dut (
    .CLK(CLK), .nRST(nRST), .run(run), .halt_req(halt_req), .opcode(opcode),
    .zflag(zflag), .mem_ack(mem_ack), .exec_done(exec_done),
    .Lout(Lout), .Lin(Lin), .inc(inc), .Ain(Ain), .mem_rd(mem_rd), .Iin(Iin),
    .IAout(IAout), .exec_start(exec_start), .busy(busy), .halted(halted),
    .instr_count(instr_count)
  );

  assign obs = {Lout, Lin, inc, Ain, mem_rd, Iin, IAout, exec_start, busy, halted};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    n_vec++;
    if ((Lout && IAout) || (Lin && inc)) begin
      n_err++;
      $display("FAIL bus_exclusive at %0t: Lout=%b IAout=%b Lin=%b inc=%b, required no pair both 1",
               $time, Lout, IAout, Lin, inc);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_vec++;
    if (obs !== V_ID) begin
      n_err++;
      $display("FAIL reset_strobes got %b want %b", obs, V_ID);
    end
    n_vec++;
    if (instr_count !== '0) begin
      n_err++;
      $display("FAIL reset_count got %0d want 0", instr_count);
    end
    tick();
    nRST = 1'b1;
    tick();
    tick();
    n_vec++;
    if (obs !== V_ID) begin
      n_err++;
      $display("FAIL idle_hold got %b want %b", obs, V_ID);
    end
  endtask

  task automatic test_nop();
    logic [9:0] e [6];
    e = '{V_FA, V_FM, V_FI, V_BZ, V_BZ, V_FA};
    opcode = 3'd0;
    mem_ack = 1'b1;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (obs !== e[i]) begin
        n_err++;
        $display("FAIL nop cyc%0d got %b want %b", i, obs, e[i]);
      end
      if (i < 5) tick();
    end
    exp_cnt = exp_cnt + 1'b1;
    n_vec++;
    if (instr_count !== exp_cnt) begin
      n_err++;
      $display("FAIL nop_count got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_jmp();
    logic [9:0] e [7];
    e = '{V_FA, V_FM, V_FI, V_BZ, V_JP, V_BZ, V_FA};
    opcode = 3'd1;
    for (int i = 0; i < 7; i++) begin
      n_vec++;
      if (obs !== e[i]) begin
        n_err++;
        $display("FAIL jmp cyc%0d got %b want %b", i, obs, e[i]);
      end
      if (i < 6) tick();
    end
    exp_cnt = exp_cnt + 1'b1;
    n_vec++;
    if (instr_count !== exp_cnt) begin
      n_err++;
      $display("FAIL jmp_count got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_jz();
    logic [9:0] nt [6];
    logic [9:0] tk [7];
    nt = '{V_FA, V_FM, V_FI, V_BZ, V_BZ, V_FA};
    tk = '{V_FA, V_FM, V_FI, V_BZ, V_JP, V_BZ, V_FA};
    opcode = 3'd2;
    zflag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (obs !== nt[i]) begin
        n_err++;
        $display("FAIL jz_nt cyc%0d got %b want %b", i, obs, nt[i]);
      end
      if (i < 5) tick();
    end
    zflag = 1'b1;
    for (int i = 0; i < 7; i++) begin
      n_vec++;
      if (obs !== tk[i]) begin
        n_err++;
        $display("FAIL jz_tk cyc%0d got %b want %b", i, obs, tk[i]);
      end
      if (i < 6) tick();
    end
    zflag = 1'b0;
    exp_cnt = exp_cnt + 2'd2;
    n_vec++;
    if (instr_count !== exp_cnt) begin
      n_err++;
      $display("FAIL jz_count got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_exec();
    logic [9:0] e [10];
    logic       d [10];
    e = '{V_FA, V_FM, V_FI, V_BZ, V_EX, V_BZ, V_BZ, V_BZ, V_BZ, V_FA};
    d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    opcode = 3'd5;
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (obs !== e[i]) begin
        n_err++;
        $display("FAIL exec cyc%0d got %b want %b", i, obs, e[i]);
      end
      exec_done = d[i];
      if (i < 9) tick();
    end
    exp_cnt = exp_cnt + 1'b1;
    n_vec++;
    if (instr_count !== exp_cnt) begin
      n_err++;
      $display("FAIL exec_count got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_mem_wait();
    logic [9:0] e [10];
    logic       a [10];
    e = '{V_FA, V_FM, V_FM, V_FM, V_FM, V_FM, V_FI, V_BZ, V_BZ, V_FA};
    a = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    opcode = 3'd0;
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (obs !== e[i]) begin
        n_err++;
        $display("FAIL memwait cyc%0d got %b want %b", i, obs, e[i]);
      end
      mem_ack = a[i];
      if (i < 9) tick();
    end
    exp_cnt = exp_cnt + 1'b1;
    n_vec++;
    if (instr_count !== exp_cnt) begin
      n_err++;
      $display("FAIL memwait_count got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_hlt();
    logic [9:0] e [7];
    logic       r [7];
    e = '{V_FA, V_FM, V_FI, V_BZ, V_HL, V_HL, V_FA};
    r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 3'd3;
    for (int i = 0; i < 7; i++) begin
      n_vec++;
      if (obs !== e[i]) begin
        n_err++;
        $display("FAIL hlt cyc%0d got %b want %b", i, obs, e[i]);
      end
      if (i == 4) begin
        n_vec++;
        if (instr_count !== exp_cnt + 1'b1) begin
          n_err++;
          $display("FAIL hlt_count got %0d want %0d", instr_count, exp_cnt + 1'b1);
        end
      end
      run = r[i];
      if (i < 6) tick();
    end
    exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic test_halt_req();
    logic [9:0] e [7];
    logic       h [7];
    logic       r [7];
    logic [9:0] p [6];
    logic       q [6];
    e = '{V_FA, V_FM, V_FI, V_BZ, V_BZ, V_HL, V_FA};
    h = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 3'd0;
    for (int i = 0; i < 7; i++) begin
      n_vec++;
      if (obs !== e[i]) begin
        n_err++;
        $display("FAIL halt_req cyc%0d got %b want %b", i, obs, e[i]);
      end
      halt_req = h[i];
      run = r[i];
      if (i < 6) tick();
    end
    p = '{V_FA, V_FM, V_FI, V_BZ, V_BZ, V_FA};
    q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (obs !== p[i]) begin
        n_err++;
        $display("FAIL halt_pulse cyc%0d got %b want %b", i, obs, p[i]);
      end
      halt_req = q[i];
      if (i < 5) tick();
    end
    exp_cnt = exp_cnt + 2'd2;
    n_vec++;
    if (instr_count !== exp_cnt) begin
      n_err++;
      $display("FAIL halt_req_count got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_reset_exec();
    logic [9:0] e [6];
    e = '{V_FA, V_FM, V_FI, V_BZ, V_EX, V_BZ};
    opcode = 3'd6;
    exec_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (obs !== e[i]) begin
        n_err++;
        $display("FAIL rst_exec cyc%0d got %b want %b", i, obs, e[i]);
      end
      if (i < 5) tick();
    end
    #2;
    nRST = 1'b0;
    #1;
    n_vec++;
    if (obs !== V_ID) begin
      n_err++;
      $display("FAIL async_reset_strobes got %b want %b", obs, V_ID);
    end
    n_vec++;
    if (instr_count !== '0) begin
      n_err++;
      $display("FAIL async_reset_count got %0d want 0", instr_count);
    end
    tick();
    nRST = 1'b1;
    exp_cnt = '0;
    tick();
    n_vec++;
    if (obs !== V_ID) begin
      n_err++;
      $display("FAIL post_reset_idle got %b want %b", obs, V_ID);
    end
  endtask

  task automatic test_wrap();
    opcode = 3'd0;
    mem_ack = 1'b1;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      repeat (5) tick();
      exp_cnt = exp_cnt + 1'b1;
      n_vec++;
      if (obs !== V_FA) begin
        n_err++;
        $display("FAIL wrap_state nop%0d got %b want %b", k, obs, V_FA);
      end
      n_vec++;
      if (instr_count !== exp_cnt) begin
        n_err++;
        $display("FAIL wrap_count nop%0d got %0d want %0d", k, instr_count, exp_cnt);
      end
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    exp_cnt   = '0;
    nRST      = 1'b0;
    run       = 1'b0;
    halt_req  = 1'b0;
    opcode    = '0;
    zflag     = 1'b0;
    mem_ack   = 1'b0;
    exec_done = 1'b0;
    test_reset();
    test_nop();
    test_jmp();
    test_jz();
    test_exec();
    test_mem_wait();
    test_hlt();
    test_halt_req();
    test_reset_exec();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
